// File: rtl/stream_arb_mux2.sv
// Two-input round-robin stream arbiter feeding a one-entry registered output.
// Optional macro STREAM_ARB_MUX2_CNT_EN adds saturating per-source transfer counters.
module stream_arb_mux2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_o,
    output logic              sel_o,
`ifdef STREAM_ARB_MUX2_CNT_EN
    input  logic              cnt_clr_i,
    output logic [15:0]       cnt_a_o,
    output logic [15:0]       cnt_b_o,
`endif
    input  logic              y_ready_i
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic              y_valid_q;
    logic [DATA_W-1:0] y_q;
    logic              sel_q;
    logic              last_grant_q;

    logic              can_load;
    logic              grant_valid;
    logic              grant_id;
    logic              xfer;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        can_load    = !y_valid_q || y_ready_i;
        grant_valid = a_valid_i || b_valid_i;
        // On contention the source that did not win last time gets the slot.
        if (a_valid_i && b_valid_i) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = b_valid_i ? SRC_B : SRC_A;
        end
        xfer      = can_load && grant_valid;
        a_ready_o = xfer && (grant_id == SRC_A);
        b_ready_o = xfer && (grant_id == SRC_B);
        win_data  = (grant_id == SRC_B) ? b_i : a_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_valid_q    <= 1'b0;
            y_q          <= '0;
            sel_q        <= SRC_A;
            last_grant_q <= SRC_B;
        end else if (xfer) begin
            y_valid_q    <= 1'b1;
            y_q          <= win_data;
            sel_q        <= grant_id;
            last_grant_q <= grant_id;
        end else if (y_ready_i) begin
            y_valid_q <= 1'b0;
        end
    end

    assign y_valid_o = y_valid_q;
    assign y_o       = y_q;
    assign sel_o     = sel_q;

`ifdef STREAM_ARB_MUX2_CNT_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (cnt_clr_i) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (a_ready_o && cnt_a_q != 16'hFFFF) cnt_a_d = cnt_a_q + 16'd1;
            if (b_ready_o && cnt_b_q != 16'hFFFF) cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a_o = cnt_a_q;
    assign cnt_b_o = cnt_b_q;
`endif

endmodule

// File: tb/tb_stream_arb_mux2.sv
// Randomised self-checking bench for stream_arb_mux2 against a behavioural model
// plus an in-order scoreboard of accepted words.
module tb_stream_arb_mux2;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_valid_i, b_valid_i, y_ready_i;
    logic [DATA_W-1:0] a_i, b_i;
    logic              a_ready_o, b_ready_o, y_valid_o, sel_o;
    logic [DATA_W-1:0] y_o;
`ifdef STREAM_ARB_MUX2_CNT_EN
    logic              cnt_clr_i;
    logic [15:0]       cnt_a_o, cnt_b_o;
`endif

    always #5 clk = ~clk;

    stream_arb_mux2 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid_i (a_valid_i),
        .a_i       (a_i),
        .a_ready_o (a_ready_o),
        .b_valid_i (b_valid_i),
        .b_i       (b_i),
        .b_ready_o (b_ready_o),
        .y_valid_o (y_valid_o),
        .y_o       (y_o),
        .sel_o     (sel_o),
`ifdef STREAM_ARB_MUX2_CNT_EN
        .cnt_clr_i (cnt_clr_i),
        .cnt_a_o   (cnt_a_o),
        .cnt_b_o   (cnt_b_o),
`endif
        .y_ready_i (y_ready_i)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model state: who was served last, and the output register contents.
    bit                m_last;
    bit                m_full;
    logic [DATA_W-1:0] m_y;
    bit                m_sel;
    int unsigned       m_cnt_a, m_cnt_b;
    logic [DATA_W-1:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_full  = 1'b0;
        m_y     = '0;
        m_sel   = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        sb.delete();
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic step();
        bit                free, have, who, clr;
        logic [DATA_W-1:0] head;
        @(negedge clk);
        free = !m_full || y_ready_i;
        have = 1'b1;
        who  = 1'b0;
        if (a_valid_i && b_valid_i) who = !m_last;
        else if (b_valid_i)         who = 1'b1;
        else if (!a_valid_i)        have = 1'b0;
        check_eq("a_ready", a_ready_o, free && have && !who);
        check_eq("b_ready", b_ready_o, free && have && who);
        if (y_valid_o && y_ready_i) begin
            check_eq("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                head = sb.pop_front();
                check_eq("sb_order", y_o, head);
            end
        end
`ifdef STREAM_ARB_MUX2_CNT_EN
        clr = cnt_clr_i;
`else
        clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (free && have) begin
            m_full = 1'b1;
            m_y    = who ? b_i : a_i;
            m_sel  = who;
            m_last = who;
            sb.push_back(m_y);
            if (!who && m_cnt_a < 16'hFFFF) m_cnt_a++;
            if (who && m_cnt_b < 16'hFFFF) m_cnt_b++;
        end else if (y_ready_i) begin
            m_full = 1'b0;
        end
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end
        check_eq("y_valid", y_valid_o, m_full);
        check_eq("y", y_o, m_y);
        check_eq("sel", sel_o, m_sel);
`ifdef STREAM_ARB_MUX2_CNT_EN
        check_eq("cnt_a", cnt_a_o, m_cnt_a);
        check_eq("cnt_b", cnt_b_o, m_cnt_b);
`endif
    endtask

    task automatic drive(input bit av, input logic [DATA_W-1:0] ad, input bit bv,
                         input logic [DATA_W-1:0] bd, input bit yr);
        a_valid_i = av;
        a_i       = ad;
        b_valid_i = bv;
        b_i       = bd;
        y_ready_i = yr;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef STREAM_ARB_MUX2_CNT_EN
        cnt_clr_i = 1'b0;
`endif
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset / idle
        check_eq("rst_y_valid", y_valid_o, 1'b0);
        check_eq("rst_y", y_o, 8'h00);
        check_eq("rst_sel", sel_o, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (5) step();

        // Contention: strict alternation starting with A
        drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("cont_y", y_o, (i % 2 == 0) ? 8'hA5 : 8'h5A);
            check_eq("cont_sel", sel_o, (i % 2 == 0) ? 1'b0 : 1'b1);
        end

        // Backpressure
        drive(1'b1, 8'h3C, 1'b0, '0, 1'b1);
        step();
        check_eq("bp_load", y_o, 8'h3C);
        drive(1'b0, '0, 1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold", y_o, 8'h3C);
        end
        y_ready_i = 1'b1;
        step();
        check_eq("bp_y", y_o, 8'hC3);
        check_eq("bp_sel", sel_o, 1'b1);

        // Single-source streaming
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0, '0, 1'b1);
            step();
            check_eq("str_y", y_o, i);
            check_eq("str_sel", sel_o, 1'b0);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 3) != 0,
                  DATA_W'($urandom), $urandom_range(0, 2) != 0);
            step();
        end

        // Mid-operation reset
        drive(1'b1, 8'hFF, 1'b0, '0, 1'b0);
        step();
        check_eq("mr_full", y_valid_o, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check_eq("mr_y_valid", y_valid_o, 1'b0);
        check_eq("mr_y", y_o, 8'h00);
        model_reset();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        step();
        check_eq("mr_first", y_o, 8'h11);
        check_eq("mr_first_sel", sel_o, 1'b0);
        step();
        check_eq("mr_second", y_o, 8'h22);

`ifdef STREAM_ARB_MUX2_CNT_EN
        drive(1'b1, 8'h01, 1'b0, '0, 1'b1);
        for (int i = 0; i < 70000; i++) step();
        check_eq("cnt_sat", cnt_a_o, 16'hFFFF);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check_eq("cnt_clr", cnt_a_o, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux2.md
Name: stream_arb_mux2

Overview:
Two-input arbitrated stream multiplexer. It sits directly upstream of the consumer of the 8-bit 2:1 mux datapath and replaces the free-running select with a registered, handshaked selection. It arbitrates two valid/ready byte streams round-robin, forwards the winner through a one-entry output register, and reports which source won.

Parameters:
DATA_W, 8, width of each input and output data word
- Legal range: 1..32.

Ports:
clk       input   1        rising-edge clock
reset_n   input   1        asynchronous, active-low reset
a_valid_i input   1        stream A word valid
a_i       input   DATA_W   stream A data
a_ready_o output  1        stream A word accepted this cycle (when high with a_valid_i)
b_valid_i input   1        stream B word valid
b_i       input   DATA_W   stream B data
b_ready_o output  1        stream B word accepted this cycle (when high with b_valid_i)
y_valid_o output  1        output word valid
y_o       output  DATA_W   output data (registered)
sel_o     output  1        source of y_o: 0 = A, 1 = B (registered with y_o)
y_ready_i input   1        downstream accepts y_o

Behaviour:
- Reset (async assert, sync release):
  - y_valid_o=0, y_o=0, sel_o=0.
  - Internal last_grant=1, so A wins the first contention.
- Output register state:
  - EMPTY (y_valid_o=0) or FULL (y_valid_o=1).
  - can_load = !y_valid_o | y_ready_i.
- Grant (combinational from valids and last_grant):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the source != last_grant.
  - Neither valid -> no grant.
- Ready outputs:
  - a_ready_o = can_load & grant==A.
  - b_ready_o = can_load & grant==B.
  - Never both high in the same cycle.
  - Ready to a non-winning input is 0 even when the register is free.
- Transfer (valid & ready on the granted input), at the clock edge:
  - y_o <= winner data; sel_o <= winner id; y_valid_o <= 1; last_grant <= winner id.
- Drain:
  - y_valid_o & y_ready_i with no new transfer -> y_valid_o <= 0.
  - y_o and sel_o hold their last values.
- Simultaneous drain and load: the register is overwritten with the new word, y_valid_o stays 1. Full throughput is 1 word/cycle.
- Stall: y_valid_o=1 & y_ready_i=0 -> y_o and sel_o stay stable, both ready outputs are 0, last_grant is unchanged.
- Latency: an input word accepted at edge N appears on y_o after edge N, i.e. one cycle.
- last_grant changes only on an accepted transfer.
  - Valids that drop without a transfer do not change fairness.
  - Under continuous dual request, grants alternate strictly A,B,A,B.
- Inputs may drop valid before acceptance; no words are dropped or duplicated.
- Reset asserted mid-transfer: the output register is cleared immediately and any pending word is discarded. After release, arbitration restarts with A priority.
- Constraint: no combinational path from y_ready_i to y_valid_o or y_o. The paths y_ready_i -> a_ready_o/b_ready_o are permitted.

Optional Feature:
STREAM_ARB_MUX2_CNT_EN
- Defined:
  - Adds outputs cnt_a_o[15:0] and cnt_b_o[15:0].
  - Each counts accepted transfers from its source.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Async reset to 0.
  - Adds input cnt_clr_i, a synchronous clear of both counters. If a transfer occurs in the same cycle as cnt_clr_i, the counter result is 0 (clear wins).
- Undefined: those ports and that logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset/idle: reset_n=0, then release with all valids=0 -> y_valid_o=0, y_o=8'h00, sel_o=0, a_ready_o=b_ready_o=0 for 5 cycles.
2. Contention: a_i=8'hA5 and b_i=8'h5A both valid, y_ready_i=1 held for 4 cycles.
   - Outputs: 8'hA5/sel 0, 8'h5A/sel 1, 8'hA5/sel 0, 8'h5A/sel 1 on consecutive cycles, each 1 cycle after acceptance.
3. Backpressure: load a_i=8'h3C, then y_ready_i=0 for 3 cycles while b_valid_i=1 with b_i=8'hC3.
   - y_o holds 8'h3C, b_ready_o=0 throughout.
   - Raise y_ready_i -> b_ready_o=1 in the same cycle, and next cycle y_o=8'hC3, sel_o=1.
4. Single source streaming: only A valid, data 0x00..0x09, y_ready_i=1.
   - 10 words out in order on 10 consecutive cycles, sel_o=0, b_ready_o=0.
5. Mid-operation reset: with y_valid_o=1 holding 8'hFF, pulse reset_n low asynchronously between edges.
   - y_valid_o drops immediately.
   - After release with both valids high, the first output is A's data.
6. (STREAM_ARB_MUX2_CNT_EN) 70000 A transfers -> cnt_a_o=16'hFFFF. cnt_clr_i for 1 cycle concurrent with a transfer -> cnt_a_o=0.
